imm_ext_seq: RTL

//  Immediate-generation sequencer for the 16-bit datapath: takes instruction immediate fields,

---
 rtl/imm_ext_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/imm_ext_seq.sv
// Immediate-generation sequencer: extends 4/8-bit immediates and merges a PREFIX upper byte
// with the following instruction. Optional prefix timeout under `IMM_PREFIX_TIMEOUT_EN.
module imm_ext_seq #(
   parameter int DATA_W  = 16,
   parameter int LO_W    = 8,
   parameter int NIB_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [LO_W-1:0]   instr_imm,
   input  logic [1:0]        imm_kind,
   input  logic              flush,
   output logic              imm_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm_out,
   output logic              prefix_pending,
   output logic              prefix_drop
);

   localparam int UP_W = DATA_W - LO_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PREFIX = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t              state_r;
   logic [UP_W-1:0]     upper_r;
   logic [DATA_W-1:0]   imm_out_r;
   logic                drop_r;
   logic                accept_s;

   // Sign/zero extension of a non-prefix immediate field by kind.
   function automatic logic [DATA_W-1:0] extend(input logic [1:0] kind, input logic [LO_W-1:0] imm);
      case (kind)
         2'b00:   extend = {{(DATA_W-NIB_W){imm[NIB_W-1]}}, imm[NIB_W-1:0]};
         2'b01:   extend = {{(DATA_W-LO_W){imm[LO_W-1]}}, imm};
         2'b10:   extend = {{(DATA_W-LO_W){1'b0}}, imm};
         default: extend = {DATA_W{1'b0}};
      endcase
   endfunction

   assign accept_s       = instr_valid & (state_r != ST_HOLD);
   assign instr_ready    = (state_r != ST_HOLD);
   assign imm_valid      = (state_r == ST_HOLD);
   assign prefix_pending = (state_r == ST_PREFIX);
   assign imm_out        = imm_out_r;

`ifdef IMM_PREFIX_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_r;
   assign prefix_drop = drop_r;
`else
   assign prefix_drop = 1'b0;
`endif

   // Sequencer state, captured upper byte and held result; flush beats every other event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         upper_r   <= {UP_W{1'b0}};
         imm_out_r <= {DATA_W{1'b0}};
         drop_r    <= 1'b0;
`ifdef IMM_PREFIX_TIMEOUT_EN
         cnt_r     <= {CNT_W{1'b0}};
`endif
      end else if (flush) begin
         state_r <= ST_IDLE;
         upper_r <= {UP_W{1'b0}};
         drop_r  <= 1'b0;
`ifdef IMM_PREFIX_TIMEOUT_EN
         cnt_r   <= {CNT_W{1'b0}};
`endif
      end else begin
         drop_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (imm_kind == 2'b11) begin
                     upper_r <= instr_imm[UP_W-1:0];
                     state_r <= ST_PREFIX;
`ifdef IMM_PREFIX_TIMEOUT_EN
                     cnt_r   <= {CNT_W{1'b0}};
`endif
                  end else begin
                     imm_out_r <= extend(imm_kind, instr_imm);
                     state_r   <= ST_HOLD;
                  end
               end
            end
            ST_PREFIX: begin
               if (accept_s) begin
`ifdef IMM_PREFIX_TIMEOUT_EN
                  cnt_r <= {CNT_W{1'b0}};
`endif
                  // Last prefix wins; any other kind is the raw low byte, no extension.
                  if (imm_kind == 2'b11) begin
                     upper_r <= instr_imm[UP_W-1:0];
                  end else begin
                     imm_out_r <= {upper_r, instr_imm};
                     state_r   <= ST_HOLD;
                  end
               end
`ifdef IMM_PREFIX_TIMEOUT_EN
               else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                  state_r <= ST_IDLE;
                  upper_r <= {UP_W{1'b0}};
                  drop_r  <= 1'b1;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
`endif
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
